// File: rtl/line_fetcher.sv
// Line fetcher: on each display line-load request, reads one line of pixels from memory in
// fixed-length bursts and streams the returned beats into the line FIFO. A frame-start clear
// flushes the FIFO and abandons any line in flight.
module line_fetcher #(
  parameter int unsigned H_ACTIVE   = 1024,
  parameter int unsigned BURST_LEN  = 8,
  parameter int unsigned FIFO_DEPTH = 2048,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int unsigned ADDR_W     = 23
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iLOAD_REQ,
  input  logic [12:0]       iLOAD_VLINE,
  input  logic              iCLEAR,
  output logic              oMEM_RD_REQ,
  output logic [ADDR_W-1:0] oMEM_ADDR,
  input  logic              iMEM_ACK,
  input  logic              iMEM_RD_VALID,
  input  logic [23:0]       iMEM_RD_DATA,
  output logic              oFIFO_WE,
  output logic [23:0]       oFIFO_WDATA,
  input  logic [11:0]       iFIFO_WUSEDW,
  output logic              oFIFO_ACLR,
  output logic              oBUSY,
  output logic              oOVERRUN
);

  localparam int unsigned IssW       = $clog2(H_ACTIVE + 1);
  localparam int unsigned BeatW      = $clog2(BURST_LEN + 1);
  localparam int unsigned SpaceLimit = FIFO_DEPTH - BURST_LEN;

  typedef enum logic [2:0] {StIdle, StWaitSpace, StReq, StXfer, StDrain} stateT;

  stateT            stateQ, stateD;
  logic [12:0]      lineQ, lineD;
  logic [IssW-1:0]  issuedQ, issuedD;   // words requested so far on this line
  logic [BeatW-1:0] beatQ, beatD;       // beats received in the current burst
  logic             loadPrevQ, clearPrevQ;
  logic             weQ, aclrQ, aclrPendQ, overrunQ;
  logic [23:0]      wdataQ;

  logic loadEdge, clearEdge, lastBeat, lineDone, haveSpace, weD;

  // The display controller holds its requests for two cycles; act only on the rising edge.
  assign loadEdge  = iLOAD_REQ & ~loadPrevQ;
  assign clearEdge = iCLEAR & ~clearPrevQ;
  assign lastBeat  = iMEM_RD_VALID && (beatQ == BeatW'(BURST_LEN - 1));
  assign lineDone  = (issuedQ == IssW'(H_ACTIVE));
  assign haveSpace = (32'(iFIFO_WUSEDW) <= SpaceLimit);

  // A beat is written only while transferring and never during a FIFO clear pulse.
  assign weD = (stateQ == StXfer) && iMEM_RD_VALID && !clearEdge && !aclrPendQ;

  // Next-state logic for the fetch FSM and its line/burst counters.
  always_comb begin
    stateD  = stateQ;
    lineD   = lineQ;
    issuedD = issuedQ;
    beatD   = beatQ;
    unique case (stateQ)
      StIdle: begin
        if (loadEdge && !clearEdge) begin
          lineD   = iLOAD_VLINE;
          issuedD = '0;
          beatD   = '0;
          stateD  = StWaitSpace;
        end
      end
      StWaitSpace: begin
        if (clearEdge) stateD = StIdle;
        else if (haveSpace) stateD = StReq;
      end
      StReq: begin
        if (clearEdge) begin
          stateD = StIdle;
        end else if (iMEM_ACK) begin
          issuedD = issuedQ + IssW'(BURST_LEN);
          beatD   = '0;
          stateD  = StXfer;
        end
      end
      StXfer: begin
        if (iMEM_RD_VALID) beatD = beatQ + BeatW'(1);
        if (lastBeat) begin
          beatD  = '0;
          stateD = (clearEdge || lineDone) ? StIdle : StWaitSpace;
        end else if (clearEdge) begin
          stateD = StDrain;
        end
      end
      StDrain: begin
        if (iMEM_RD_VALID) beatD = beatQ + BeatW'(1);
        if (lastBeat) begin
          beatD  = '0;
          stateD = StIdle;
        end
      end
      default: stateD = StIdle;
    endcase
  end

  // FSM state and counter registers.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      stateQ  <= StIdle;
      lineQ   <= '0;
      issuedQ <= '0;
      beatQ   <= '0;
    end else begin
      stateQ  <= stateD;
      lineQ   <= lineD;
      issuedQ <= issuedD;
      beatQ   <= beatD;
    end
  end

  // Edge detectors, registered FIFO write path, clear pulse stretcher and sticky overrun.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      loadPrevQ  <= 1'b0;
      clearPrevQ <= 1'b0;
      weQ        <= 1'b0;
      wdataQ     <= '0;
      aclrQ      <= 1'b1;
      aclrPendQ  <= 1'b0;
      overrunQ   <= 1'b0;
    end else begin
      loadPrevQ  <= iLOAD_REQ;
      clearPrevQ <= iCLEAR;
      weQ        <= weD;
      if (weD) wdataQ <= iMEM_RD_DATA;
      aclrQ      <= clearEdge | aclrPendQ;
      aclrPendQ  <= clearEdge;
      if (clearEdge) overrunQ <= 1'b0;
      else if (loadEdge && (stateQ != StIdle)) overrunQ <= 1'b1;
    end
  end

  assign oMEM_RD_REQ = (stateQ == StReq);
  assign oMEM_ADDR   = (stateQ == StReq) ?
                       ADDR_W'(BASE_ADDR) + ADDR_W'(lineQ) * ADDR_W'(H_ACTIVE) + ADDR_W'(issuedQ) :
                       '0;
  assign oFIFO_WE    = weQ;
  assign oFIFO_WDATA = wdataQ;
  assign oFIFO_ACLR  = aclrQ;
  assign oBUSY       = (stateQ != StIdle);
  assign oOVERRUN    = overrunQ;

endmodule

// File: tb/tb_line_fetcher.sv
// Bench for line_fetcher: a randomized memory model answers read requests with BURST_LEN beats
// and per-scenario tasks compare what reaches the FIFO against the line/burst arithmetic.
`timescale 1ns/1ps
module tb_line_fetcher;

  localparam int unsigned H     = 16;
  localparam int unsigned B     = 8;
  localparam int unsigned DEPTH = 2048;
  localparam int unsigned BASE  = 'h100;
  localparam int unsigned AW    = 23;

  logic          iCLK = 1'b0;
  logic          iRST = 1'b1;
  logic          iLOAD_REQ = 1'b0;
  logic [12:0]   iLOAD_VLINE = '0;
  logic          iCLEAR = 1'b0;
  logic          iMEM_ACK = 1'b0;
  logic          iMEM_RD_VALID = 1'b0;
  logic [23:0]   iMEM_RD_DATA = '0;
  logic [11:0]   iFIFO_WUSEDW = '0;
  logic          oMEM_RD_REQ, oFIFO_WE, oFIFO_ACLR, oBUSY, oOVERRUN;
  logic [AW-1:0] oMEM_ADDR;
  logic [23:0]   oFIFO_WDATA;

  line_fetcher #(
    .H_ACTIVE  (H),
    .BURST_LEN (B),
    .FIFO_DEPTH(DEPTH),
    .BASE_ADDR (BASE),
    .ADDR_W    (AW)
  ) dut (
    .iCLK         (iCLK),
    .iRST         (iRST),
    .iLOAD_REQ    (iLOAD_REQ),
    .iLOAD_VLINE  (iLOAD_VLINE),
    .iCLEAR       (iCLEAR),
    .oMEM_RD_REQ  (oMEM_RD_REQ),
    .oMEM_ADDR    (oMEM_ADDR),
    .iMEM_ACK     (iMEM_ACK),
    .iMEM_RD_VALID(iMEM_RD_VALID),
    .iMEM_RD_DATA (iMEM_RD_DATA),
    .oFIFO_WE     (oFIFO_WE),
    .oFIFO_WDATA  (oFIFO_WDATA),
    .iFIFO_WUSEDW (iFIFO_WUSEDW),
    .oFIFO_ACLR   (oFIFO_ACLR),
    .oBUSY        (oBUSY),
    .oOVERRUN     (oOVERRUN)
  );

  always #5 iCLK = ~iCLK;

  int nChecks = 0;
  int nPass = 0;
  int cycle = 0;        // number of rising edges so far
  int beatsLeft = 0;    // beats the memory still owes for the accepted burst
  int busyFall = -1;
  int weAclr = 0;
  int protoErr = 0;
  bit busyPrev = 1'b0;

  logic [23:0]   beatQ[$];
  int            beatCyc[$];   // edge at which each beat is sampled
  logic [23:0]   wrQ[$];
  int            wrCyc[$];     // edge after which each FIFO write is visible
  int            aclrCyc[$];
  int            rdReqCyc[$];
  logic [AW-1:0] reqQ[$];

  function automatic logic [AW-1:0] exp_addr(input int unsigned line, input int unsigned k);
    int unsigned a;
    a = BASE + line * H + k * B;
    return AW'(a);
  endfunction

  // One clock: observe outputs after the edge, then drive the memory side for the next edge.
  task automatic step();
    @(posedge iCLK);
    #1;
    cycle++;
    if (oFIFO_WE === 1'b1) begin
      wrQ.push_back(oFIFO_WDATA);
      wrCyc.push_back(cycle);
    end
    if (oFIFO_WE === 1'b1 && oFIFO_ACLR === 1'b1) weAclr++;
    if (oFIFO_ACLR === 1'b1) aclrCyc.push_back(cycle);
    if (oMEM_RD_REQ === 1'b1) rdReqCyc.push_back(cycle);
    if (busyPrev && oBUSY === 1'b0) busyFall = cycle;
    busyPrev = (oBUSY === 1'b1);
    iMEM_RD_VALID = 1'b0;
    iMEM_RD_DATA  = 24'($urandom);
    if (iMEM_ACK) begin
      iMEM_ACK  = 1'b0;
      beatsLeft = B;
      if (oMEM_RD_REQ === 1'b1) protoErr++;
    end else if (oMEM_RD_REQ === 1'b1) begin
      if (beatsLeft != 0) protoErr++;
      else if ($urandom_range(0, 2) == 0) begin
        iMEM_ACK = 1'b1;
        reqQ.push_back(oMEM_ADDR);
      end
    end
    if (beatsLeft != 0 && $urandom_range(0, 3) != 0) begin
      iMEM_RD_VALID = 1'b1;
      beatQ.push_back(iMEM_RD_DATA);
      beatCyc.push_back(cycle + 1);
      beatsLeft--;
    end
  endtask

  task automatic clear_log();
    beatQ.delete(); beatCyc.delete(); wrQ.delete(); wrCyc.delete();
    aclrCyc.delete(); rdReqCyc.delete(); reqQ.delete();
    busyFall = -1;
    busyPrev = (oBUSY === 1'b1);
  endtask

  task automatic load_pulse(input int unsigned line);
    iLOAD_VLINE = 13'(line);
    iLOAD_REQ   = 1'b1;
    step();
    step();
    iLOAD_REQ   = 1'b0;
  endtask

  task automatic clear_pulse();
    iCLEAR = 1'b1;
    step();
    step();
    iCLEAR = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (oBUSY === 1'b0 && beatsLeft == 0 && !iMEM_ACK) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (3) step();
  endtask

  task automatic test_reset();
    iRST = 1'b1;
    repeat (3) step();
    nChecks++; if (oMEM_RD_REQ !== 1'b0) $display("FAIL rst_rdreq: got %b want 0", oMEM_RD_REQ); else nPass++;
    nChecks++; if (oMEM_ADDR !== '0) $display("FAIL rst_addr: got %h want 0", oMEM_ADDR); else nPass++;
    nChecks++; if (oFIFO_WE !== 1'b0) $display("FAIL rst_we: got %b want 0", oFIFO_WE); else nPass++;
    nChecks++; if (oFIFO_WDATA !== '0) $display("FAIL rst_wdata: got %h want 0", oFIFO_WDATA); else nPass++;
    nChecks++; if (oFIFO_ACLR !== 1'b1) $display("FAIL rst_aclr: got %b want 1", oFIFO_ACLR); else nPass++;
    nChecks++; if (oBUSY !== 1'b0) $display("FAIL rst_busy: got %b want 0", oBUSY); else nPass++;
    nChecks++; if (oOVERRUN !== 1'b0) $display("FAIL rst_overrun: got %b want 0", oOVERRUN); else nPass++;
    iRST = 1'b0;
    step();
    nChecks++; if (oFIFO_ACLR !== 1'b0) $display("FAIL rst_release_aclr: got %b want 0", oFIFO_ACLR); else nPass++;
  endtask

  // Full line load: two bursts at consecutive addresses, every beat written one cycle later.
  task automatic test_load(input string name, input int unsigned line, input int unsigned usedw);
    bit ok;
    int expFall;
    clear_log();
    iFIFO_WUSEDW = 12'(usedw);
    load_pulse(line);
    wait_idle(600, ok);
    nChecks++; if (!ok) $display("FAIL %s_timeout: got busy want idle", name); else nPass++;
    nChecks++; if (reqQ.size() != 2) $display("FAIL %s_reqs: got %0d want 2", name, reqQ.size()); else nPass++;
    for (int k = 0; k < 2 && k < reqQ.size(); k++) begin
      nChecks++;
      if (reqQ[k] !== exp_addr(line, k))
        $display("FAIL %s_addr%0d: got %h want %h", name, k, reqQ[k], exp_addr(line, k));
      else nPass++;
    end
    nChecks++; if (wrQ.size() != H) $display("FAIL %s_writes: got %0d want %0d", name, wrQ.size(), H); else nPass++;
    for (int i = 0; i < wrQ.size() && i < beatQ.size(); i++) begin
      nChecks++;
      if (wrQ[i] !== beatQ[i] || wrCyc[i] != beatCyc[i])
        $display("FAIL %s_write%0d: got %h@%0d want %h@%0d", name, i, wrQ[i], wrCyc[i],
                 beatQ[i], beatCyc[i]);
      else nPass++;
    end
    expFall = (beatQ.size() >= H) ? beatCyc[H-1] : -2;
    nChecks++; if (busyFall != expFall) $display("FAIL %s_busy_fall: got %0d want %0d", name, busyFall, expFall); else nPass++;
    iFIFO_WUSEDW = '0;
  endtask

  task automatic test_wait_space();
    bit ok;
    int s;
    clear_log();
    iFIFO_WUSEDW = 12'd2045;
    load_pulse(1);
    for (int i = 0; i < 20; i++) begin
      iFIFO_WUSEDW = 12'($urandom_range(2041, 2047));
      step();
    end
    nChecks++; if (rdReqCyc.size() != 0) $display("FAIL space_no_req: got %0d req cycles want 0", rdReqCyc.size()); else nPass++;
    nChecks++; if (oBUSY !== 1'b1) $display("FAIL space_busy: got %b want 1", oBUSY); else nPass++;
    iFIFO_WUSEDW = 12'd2040;
    s = cycle;
    repeat (3) step();
    nChecks++;
    if (rdReqCyc.size() == 0 || rdReqCyc[0] > s + 1)
      $display("FAIL space_req_latency: got %0d want <= %0d", (rdReqCyc.size() == 0) ? -1 : rdReqCyc[0], s + 1);
    else nPass++;
    wait_idle(600, ok);
    nChecks++; if (wrQ.size() != H) $display("FAIL space_writes: got %0d want %0d", wrQ.size(), H); else nPass++;
    nChecks++;
    if (reqQ.size() < 1 || reqQ[0] !== exp_addr(1, 0))
      $display("FAIL space_addr0: got %h want %h", (reqQ.size() == 0) ? '0 : reqQ[0], exp_addr(1, 0));
    else nPass++;
    iFIFO_WUSEDW = '0;
  endtask

  task automatic test_overrun();
    bit ok;
    clear_log();
    load_pulse(5);
    for (int i = 0; i < 300 && wrQ.size() == 0; i++) step();
    nChecks++; if (oOVERRUN !== 1'b0) $display("FAIL ovr_before: got %b want 0", oOVERRUN); else nPass++;
    load_pulse(9);
    wait_idle(600, ok);
    nChecks++; if (oOVERRUN !== 1'b1) $display("FAIL ovr_set: got %b want 1", oOVERRUN); else nPass++;
    nChecks++; if (wrQ.size() != H) $display("FAIL ovr_writes: got %0d want %0d", wrQ.size(), H); else nPass++;
    nChecks++;
    if (reqQ.size() != 2 || reqQ[0] !== exp_addr(5, 0) || reqQ[1] !== exp_addr(5, 1))
      $display("FAIL ovr_reqs: got %0d reqs first %h want 2 reqs first %h", reqQ.size(),
               (reqQ.size() == 0) ? '0 : reqQ[0], exp_addr(5, 0));
    else nPass++;
    clear_pulse();
    step();
    nChecks++; if (oOVERRUN !== 1'b0) $display("FAIL ovr_cleared: got %b want 0", oOVERRUN); else nPass++;
  endtask

  task automatic test_clear_mid_burst();
    bit ok;
    int clrCyc;
    int expFall;
    clear_log();
    load_pulse(2);
    for (int i = 0; i < 300 && !(beatCyc.size() >= 3 && cycle >= beatCyc[2]); i++) step();
    iCLEAR = 1'b1;
    clrCyc = cycle + 1;
    step();
    step();
    iCLEAR = 1'b0;
    wait_idle(300, ok);
    repeat (10) step();
    nChecks++;
    if (aclrCyc.size() != 2 || aclrCyc[0] != clrCyc || aclrCyc[1] != clrCyc + 1)
      $display("FAIL clr_aclr: got %0d cycles from %0d want 2 from %0d", aclrCyc.size(),
               (aclrCyc.size() == 0) ? -1 : aclrCyc[0], clrCyc);
    else nPass++;
    nChecks++; if (wrQ.size() != 3) $display("FAIL clr_writes: got %0d want 3", wrQ.size()); else nPass++;
    for (int i = 0; i < wrQ.size() && i < 3; i++) begin
      nChecks++;
      if (wrQ[i] !== beatQ[i]) $display("FAIL clr_data%0d: got %h want %h", i, wrQ[i], beatQ[i]);
      else nPass++;
    end
    nChecks++; if (reqQ.size() != 1) $display("FAIL clr_reqs: got %0d want 1", reqQ.size()); else nPass++;
    expFall = (beatCyc.size() >= B) ? beatCyc[B-1] : -2;
    nChecks++; if (busyFall != expFall) $display("FAIL clr_idle_at_beat8: got %0d want %0d", busyFall, expFall); else nPass++;
  endtask

  task automatic test_simultaneous();
    int clrCyc;
    clear_log();
    iLOAD_VLINE = 13'd7;
    iLOAD_REQ = 1'b1;
    iCLEAR = 1'b1;
    clrCyc = cycle + 1;
    step();
    step();
    iLOAD_REQ = 1'b0;
    iCLEAR = 1'b0;
    repeat (12) step();
    nChecks++;
    if (aclrCyc.size() != 2 || aclrCyc[0] != clrCyc)
      $display("FAIL sim_aclr: got %0d cycles want 2 from %0d", aclrCyc.size(), clrCyc);
    else nPass++;
    nChecks++; if (rdReqCyc.size() != 0) $display("FAIL sim_no_req: got %0d want 0", rdReqCyc.size()); else nPass++;
    nChecks++; if (oOVERRUN !== 1'b0) $display("FAIL sim_overrun: got %b want 0", oOVERRUN); else nPass++;
    nChecks++; if (oBUSY !== 1'b0) $display("FAIL sim_busy: got %b want 0", oBUSY); else nPass++;
  endtask

  task automatic test_reset_mid_xfer();
    clear_log();
    load_pulse(4);
    for (int i = 0; i < 300 && wrQ.size() == 0; i++) step();
    iRST = 1'b1;
    step();
    nChecks++; if (oMEM_RD_REQ !== 1'b0) $display("FAIL rx_rdreq: got %b want 0", oMEM_RD_REQ); else nPass++;
    nChecks++; if (oMEM_ADDR !== '0) $display("FAIL rx_addr: got %h want 0", oMEM_ADDR); else nPass++;
    nChecks++; if (oFIFO_WE !== 1'b0) $display("FAIL rx_we: got %b want 0", oFIFO_WE); else nPass++;
    nChecks++; if (oFIFO_WDATA !== '0) $display("FAIL rx_wdata: got %h want 0", oFIFO_WDATA); else nPass++;
    nChecks++; if (oFIFO_ACLR !== 1'b1) $display("FAIL rx_aclr: got %b want 1", oFIFO_ACLR); else nPass++;
    nChecks++; if (oBUSY !== 1'b0) $display("FAIL rx_busy: got %b want 0", oBUSY); else nPass++;
    nChecks++; if (oOVERRUN !== 1'b0) $display("FAIL rx_overrun: got %b want 0", oOVERRUN); else nPass++;
    iRST = 1'b0;
    clear_log();
    repeat (25) step();
    nChecks++; if (wrQ.size() != 0) $display("FAIL rx_stray_writes: got %0d want 0", wrQ.size()); else nPass++;
    nChecks++; if (rdReqCyc.size() != 0) $display("FAIL rx_stray_req: got %0d want 0", rdReqCyc.size()); else nPass++;
    nChecks++; if (oBUSY !== 1'b0) $display("FAIL rx_idle: got %b want 0", oBUSY); else nPass++;
  endtask

  initial begin
    test_reset();
    test_load("normal", 3, 0);
    test_wait_space();
    test_overrun();
    test_clear_mid_burst();
    test_simultaneous();
    test_reset_mid_xfer();
    test_load("top_line", 8191, 2040);
    for (int n = 0; n < 5; n++) test_load("rand", $urandom_range(0, 8191), $urandom_range(0, 2040));
    nChecks++; if (weAclr != 0) $display("FAIL we_during_aclr: got %0d cycles want 0", weAclr); else nPass++;
    nChecks++; if (protoErr != 0) $display("FAIL outstanding: got %0d violations want 0", protoErr); else nPass++;
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
